// File: rtl/tdc_pkg.sv
// Shared widths, FSM states and defaults for the multi-channel TDC time accumulator.
// Width helpers are constant functions so they can size ports and parameters.
package tdc_pkg;

   localparam int DEFAULT_SCALE = 50;

   typedef enum logic {
      IDLE,
      ACC
   } acc_state_e;

   function automatic int scale_w(input int scale);
      return $clog2(scale + 1);
   endfunction

   function automatic int term_w(input int int_w, input int frac_w, input int scale);
      int prodW;
      prodW = int_w + scale_w(scale);
      return ((prodW > frac_w) ? prodW : frac_w) + 1;
   endfunction

   function automatic int tree_st(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

   function automatic int sum_w(input int termW, input int n);
      return termW + tree_st(n);
   endfunction

   function automatic int out_w(input int sumW, input int accW);
      return sumW + accW;
   endfunction

   // Number of live operands at tree level k (level 0 is the input vector).
   function automatic int lvl_cnt(input int n, input int k);
      int c;
      c = n;
      for (int i = 0; i < k; i++) begin
         c = (c + 1) / 2;
      end
      return c;
   endfunction

endpackage

// File: rtl/tdc_add_tree.sv
// Registered pairwise adder tree with a valid bit and a sideband word of equal latency.
// One register stage per tree level; a single input degenerates to a wire.
module tdc_add_tree
   import tdc_pkg::*;
#(
   parameter int N    = 8,
   parameter int IN_W = 18,
   parameter int SB_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        vld_i,
   input  logic [SB_W-1:0]             sb_i,
   input  logic [IN_W-1:0]             data_i [N],
   output logic                        vld_o,
   output logic [SB_W-1:0]             sb_o,
   output logic [IN_W+tree_st(N)-1:0]  sum_o,
   output logic                        busy_o
);

   localparam int ST = tree_st(N);
   localparam int OW = IN_W + ST;

   generate
      if (ST == 0) begin : g_pass
         assign vld_o  = vld_i;
         assign sb_o   = sb_i;
         assign sum_o  = data_i[0];
         assign busy_o = 1'b0;
      end else begin : g_tree
         logic [OW-1:0]   lvl    [ST][N];
         logic [OW-1:0]   node_d [ST][N];
         logic [OW-1:0]   node_q [ST][N];
         logic [ST-1:0]   vld_q;
         logic [SB_W-1:0] sb_q   [ST];

         always_comb begin
            for (int j = 0; j < N; j++) begin
               lvl[0][j] = OW'(data_i[j]);
            end
            for (int k = 1; k < ST; k++) begin
               for (int j = 0; j < N; j++) begin
                  lvl[k][j] = node_q[k-1][j];
               end
            end
         end

         // An odd leftover operand is carried to the next level unchanged.
         always_comb begin
            for (int k = 0; k < ST; k++) begin
               for (int j = 0; j < N; j++) begin
                  int ia;
                  int ib;
                  ia = (2 * j < N) ? 2 * j : 0;
                  ib = (2 * j + 1 < N) ? 2 * j + 1 : 0;
                  node_d[k][j] = '0;
                  if (2 * j + 1 < lvl_cnt(N, k)) begin
                     node_d[k][j] = lvl[k][ia] + lvl[k][ib];
                  end else if (2 * j < lvl_cnt(N, k)) begin
                     node_d[k][j] = lvl[k][ia];
                  end
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q <= '0;
               for (int k = 0; k < ST; k++) begin
                  sb_q[k] <= '0;
                  for (int j = 0; j < N; j++) begin
                     node_q[k][j] <= '0;
                  end
               end
            end else begin
               vld_q[0] <= vld_i;
               sb_q[0]  <= sb_i;
               for (int k = 1; k < ST; k++) begin
                  vld_q[k] <= vld_q[k-1];
                  sb_q[k]  <= sb_q[k-1];
               end
               for (int k = 0; k < ST; k++) begin
                  for (int j = 0; j < N; j++) begin
                     node_q[k][j] <= node_d[k][j];
                  end
               end
            end
         end

         assign vld_o  = vld_q[ST-1];
         assign sb_o   = sb_q[ST-1];
         assign sum_o  = node_q[ST-1][0];
         assign busy_o = |vld_q;
      end
   endgenerate

endmodule

// File: rtl/tdc_time_accum.sv
// Multi-channel TDC time scaler: masks and scales each channel, sums them through an
// adder tree and optionally accumulates a block of events before emitting a result.
module tdc_time_accum
   import tdc_pkg::*;
#(
   parameter  int N_CH   = 8,
   parameter  int INT_W  = 11,
   parameter  int FRAC_W = 11,
   parameter  int SCALE  = DEFAULT_SCALE,
   parameter  int ACC_W  = 16,
   localparam int TERM_W = term_w(INT_W, FRAC_W, SCALE),
   localparam int SUM_W  = sum_w(TERM_W, N_CH),
   localparam int OUT_W  = out_w(SUM_W, ACC_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INT_W-1:0]  int_data  [N_CH],
   input  logic [FRAC_W-1:0] frac_data [N_CH],
   input  logic [N_CH-1:0]   ch_mask,
   input  logic              start,
   input  logic [ACC_W-1:0]  acc_len,
   input  logic              acc_clear,
   output logic [OUT_W-1:0]  out_sum,
   output logic [ACC_W-1:0]  out_cnt,
   output logic              out_dval,
   output logic              busy
);

   logic [INT_W-1:0]  int0_q  [N_CH];
   logic [FRAC_W-1:0] frac0_q [N_CH];
   logic              vld0_q;
   logic [ACC_W-1:0]  len0_q;

   logic [TERM_W-1:0] term1_q [N_CH];
   logic              vld1_q;
   logic [ACC_W-1:0]  len1_q;

   logic              tree_vld;
   logic [ACC_W-1:0]  tree_len;
   logic [SUM_W-1:0]  tree_sum;
   logic              tree_busy;
   logic [OUT_W-1:0]  tree_ext;

   acc_state_e        state_q, state_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0]  len_q, len_d;
   logic [OUT_W-1:0]  sum_q, sum_d;
   logic [ACC_W-1:0]  ocnt_q, ocnt_d;
   logic              dval_q, dval_d;

   // Masked channels enter the pipeline as zero so they contribute nothing to the sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld0_q <= 1'b0;
         len0_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            int0_q[i]  <= '0;
            frac0_q[i] <= '0;
         end
      end else begin
         vld0_q <= start;
         len0_q <= acc_len;
         for (int i = 0; i < N_CH; i++) begin
            int0_q[i]  <= ch_mask[i] ? int_data[i]  : '0;
            frac0_q[i] <= ch_mask[i] ? frac_data[i] : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld1_q <= 1'b0;
         len1_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            term1_q[i] <= '0;
         end
      end else begin
         vld1_q <= vld0_q;
         len1_q <= len0_q;
         for (int i = 0; i < N_CH; i++) begin
            term1_q[i] <= TERM_W'(int0_q[i]) * TERM_W'(SCALE) + TERM_W'(frac0_q[i]);
         end
      end
   end

   tdc_add_tree #(
      .N    (N_CH),
      .IN_W (TERM_W),
      .SB_W (ACC_W)
   ) u_tree (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (vld1_q),
      .sb_i   (len1_q),
      .data_i (term1_q),
      .vld_o  (tree_vld),
      .sb_o   (tree_len),
      .sum_o  (tree_sum),
      .busy_o (tree_busy)
   );

   assign tree_ext = OUT_W'(tree_sum);

   // acc_clear outranks a coincident tree result, which is dropped with the block.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      sum_d   = sum_q;
      ocnt_d  = ocnt_q;
      dval_d  = 1'b0;
      if (acc_clear) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (tree_vld) begin
         case (state_q)
            IDLE: begin
               if (tree_len <= ACC_W'(1)) begin
                  sum_d  = tree_ext;
                  ocnt_d = ACC_W'(1);
                  dval_d = 1'b1;
               end else begin
                  acc_d   = tree_ext;
                  cnt_d   = ACC_W'(1);
                  len_d   = tree_len;
                  state_d = ACC;
               end
            end
            ACC: begin
               if (cnt_q + ACC_W'(1) == len_q) begin
                  sum_d   = acc_q + tree_ext;
                  ocnt_d  = len_q;
                  dval_d  = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  acc_d = acc_q + tree_ext;
                  cnt_d = cnt_q + ACC_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         ocnt_q  <= '0;
         dval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         ocnt_q  <= ocnt_d;
         dval_q  <= dval_d;
      end
   end

   assign out_sum  = sum_q;
   assign out_cnt  = ocnt_q;
   assign out_dval = dval_q;
   assign busy     = (state_q == ACC) | vld0_q | vld1_q | tree_busy;

endmodule

// File: tb/tb_tdc_time_accum.sv
// Directed bench for tdc_time_accum: table of single/accumulated events on an 8-channel
// build, plus back-to-back, clear, async reset and 1/5-channel latency sequences.
module tb_tdc_time_accum;

   localparam int N_CH   = 8;
   localparam int INT_W  = 11;
   localparam int FRAC_W = 11;
   localparam int ACC_W  = 16;
   localparam int OUT_W  = 37;
   localparam int OUT1_W = 34;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [INT_W-1:0]  int_data  [N_CH];
   logic [FRAC_W-1:0] frac_data [N_CH];
   logic [N_CH-1:0]   ch_mask;
   logic              start;
   logic [ACC_W-1:0]  acc_len;
   logic              acc_clear;
   logic [OUT_W-1:0]  out_sum;
   logic [ACC_W-1:0]  out_cnt;
   logic              out_dval;
   logic              busy;

   logic              startS;
   logic [INT_W-1:0]  int1 [1];
   logic [FRAC_W-1:0] frac1 [1];
   logic [0:0]        mask1;
   logic [OUT1_W-1:0] sum1;
   logic [ACC_W-1:0]  cnt1;
   logic              dval1, busy1;
   logic [INT_W-1:0]  int5 [5];
   logic [FRAC_W-1:0] frac5 [5];
   logic [4:0]        mask5;
   logic [OUT_W-1:0]  sum5;
   logic [ACC_W-1:0]  cnt5;
   logic              dval5, busy5;

   int nVec = 0;
   int nMis = 0;
   int cyc  = 0;

   typedef struct {
      logic [OUT_W-1:0] sum;
      logic [ACC_W-1:0] cnt;
      int               cyc;
   } res_t;
   res_t resQ[$];

   typedef struct {
      logic [INT_W-1:0]  iv;
      logic [FRAC_W-1:0] fv;
      logic [N_CH-1:0]   mask;
      logic [ACC_W-1:0]  len;
      int                nEv;
      logic [OUT_W-1:0]  expSum;
      logic [ACC_W-1:0]  expCnt;
      int                expLat;
   } vec_t;
   vec_t vecs [7];

   tdc_time_accum #(.N_CH(N_CH), .INT_W(INT_W), .FRAC_W(FRAC_W), .SCALE(50), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .int_data(int_data), .frac_data(frac_data), .ch_mask(ch_mask),
      .start(start), .acc_len(acc_len), .acc_clear(acc_clear),
      .out_sum(out_sum), .out_cnt(out_cnt), .out_dval(out_dval), .busy(busy)
   );

   tdc_time_accum #(.N_CH(1), .INT_W(INT_W), .FRAC_W(FRAC_W), .SCALE(50), .ACC_W(ACC_W)) dut1 (
      .clk(clk), .rst(rst), .int_data(int1), .frac_data(frac1), .ch_mask(mask1),
      .start(startS), .acc_len(acc_len), .acc_clear(acc_clear),
      .out_sum(sum1), .out_cnt(cnt1), .out_dval(dval1), .busy(busy1)
   );

   tdc_time_accum #(.N_CH(5), .INT_W(INT_W), .FRAC_W(FRAC_W), .SCALE(50), .ACC_W(ACC_W)) dut5 (
      .clk(clk), .rst(rst), .int_data(int5), .frac_data(frac5), .ch_mask(mask5),
      .start(startS), .acc_len(acc_len), .acc_clear(acc_clear),
      .out_sum(sum5), .out_cnt(cnt5), .out_dval(dval5), .busy(busy5)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every result strobe with the cycle it appeared in.
   always @(posedge clk) begin
      #1;
      if (out_dval === 1'b1) resQ.push_back('{sum: out_sum, cnt: out_cnt, cyc: cyc});
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [INT_W-1:0] iv, input logic [FRAC_W-1:0] fv,
                                input logic [N_CH-1:0] m, input logic [ACC_W-1:0] len,
                                input logic st);
      for (int i = 0; i < N_CH; i++) begin
         int_data[i]  = iv;
         frac_data[i] = fv;
      end
      ch_mask = m;
      acc_len = len;
      start   = st;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int startCyc;
      int lat1, lat5;
      logic [63:0] s1, s5;

      applyStimulus('0, '0, '0, '0, 1'b0);
      acc_clear = 1'b0;
      startS    = 1'b0;
      int1[0]   = 11'd1;
      frac1[0]  = 11'd2;
      mask1     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         int5[i]  = 11'd1;
         frac5[i] = 11'd2;
      end
      mask5 = 5'h1F;

      vecs[0] = '{11'd1,    11'd2,    8'hFF, 16'd0, 1, 37'd416,    16'd1, 6};
      vecs[1] = '{11'd1,    11'd2,    8'h0F, 16'd0, 1, 37'd208,    16'd1, 6};
      vecs[2] = '{11'd1,    11'd2,    8'h00, 16'd0, 1, 37'd0,      16'd1, 6};
      vecs[3] = '{11'd2047, 11'd2047, 8'h01, 16'd4, 4, 37'd417588, 16'd4, 9};
      vecs[4] = '{11'd3,    11'd0,    8'hFF, 16'd1, 1, 37'd1200,   16'd1, 6};
      vecs[5] = '{11'd0,    11'd5,    8'h03, 16'd2, 2, 37'd20,     16'd2, 7};
      vecs[6] = '{11'd2047, 11'd2047, 8'h80, 16'd0, 1, 37'd104397, 16'd1, 6};

      tick(2);
      checkOutput("reset out_sum", out_sum, 0);
      checkOutput("reset out_cnt", out_cnt, 0);
      checkOutput("reset out_dval", out_dval, 0);
      checkOutput("reset busy", busy, 0);
      rst = 1'b0;
      tick(2);

      for (int v = 0; v < 7; v++) begin
         resQ.delete();
         startCyc = cyc;
         for (int e = 0; e < vecs[v].nEv; e++) begin
            applyStimulus(vecs[v].iv, vecs[v].fv, vecs[v].mask, vecs[v].len, 1'b1);
            tick();
         end
         applyStimulus('0, '0, '0, '0, 1'b0);
         tick(15);
         checkOutput($sformatf("vec%0d strobes", v), resQ.size(), 1);
         if (resQ.size() > 0) begin
            checkOutput($sformatf("vec%0d latency", v), resQ[0].cyc - startCyc, vecs[v].expLat);
            checkOutput($sformatf("vec%0d out_sum", v), resQ[0].sum, vecs[v].expSum);
            checkOutput($sformatf("vec%0d out_cnt", v), resQ[0].cnt, vecs[v].expCnt);
         end
         checkOutput($sformatf("vec%0d busy idle", v), busy, 0);
      end

      // Back-to-back single events with an incrementing coarse count.
      resQ.delete();
      startCyc = cyc;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(INT_W'(k), '0, 8'hFF, 16'd0, 1'b1);
         tick();
      end
      applyStimulus('0, '0, '0, '0, 1'b0);
      tick(15);
      checkOutput("b2b strobes", resQ.size(), 10);
      for (int k = 0; k < 10 && k < resQ.size(); k++) begin
         checkOutput($sformatf("b2b%0d out_sum", k), resQ[k].sum, 400 * (k + 1));
         checkOutput($sformatf("b2b%0d cycle", k), resQ[k].cyc - startCyc, k + 6);
      end

      // Abort a partially filled block, then fill a fresh one.
      resQ.delete();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(11'd1, 11'd2, 8'hFF, 16'd5, 1'b1);
         tick();
      end
      applyStimulus('0, '0, '0, '0, 1'b0);
      tick(8);
      checkOutput("clear busy in block", busy, 1);
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
      checkOutput("clear busy after", busy, 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(11'd2, 11'd0, 8'h01, 16'd5, 1'b1);
         tick();
      end
      applyStimulus('0, '0, '0, '0, 1'b0);
      tick(15);
      checkOutput("clear strobes", resQ.size(), 1);
      if (resQ.size() > 0) begin
         checkOutput("clear out_sum", resQ[0].sum, 500);
         checkOutput("clear out_cnt", resQ[0].cnt, 5);
      end

      // Asynchronous reset with events in flight.
      resQ.delete();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(11'd1, 11'd2, 8'hFF, 16'd0, 1'b1);
         tick();
      end
      applyStimulus('0, '0, '0, '0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async rst out_sum", out_sum, 0);
      checkOutput("async rst out_cnt", out_cnt, 0);
      checkOutput("async rst out_dval", out_dval, 0);
      checkOutput("async rst busy", busy, 0);
      #2;
      rst = 1'b0;
      tick(12);
      checkOutput("post rst strobes", resQ.size(), 0);
      checkOutput("post rst busy", busy, 0);

      // Latency of the 1- and 5-channel builds.
      lat1 = -1;
      lat5 = -1;
      s1   = '0;
      s5   = '0;
      startS = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         startS = 1'b0;
         if (dval1 === 1'b1 && lat1 < 0) begin
            lat1 = k;
            s1   = 64'(sum1);
         end
         if (dval5 === 1'b1 && lat5 < 0) begin
            lat5 = k;
            s5   = 64'(sum5);
         end
      end
      checkOutput("n1 strobe cycle", lat1, 3);
      checkOutput("n1 out_sum", s1, 52);
      checkOutput("n5 strobe cycle", lat5, 6);
      checkOutput("n5 out_sum", s5, 260);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule

// File: doc/tdc_time_accum.md
Name: tdc_time_accum

Overview:
- Parametrised successor to the single-channel TDC time-scaling stage.
- Per channel: term = coarse × SCALE + fine.
- Sums N_CH channel terms through a pipelined adder tree, with a per-channel enable mask.
- Optionally accumulates ACC_LEN consecutive events before presenting a result.
- Sits between the per-channel coarse/fine TDC decoders and the histogram/readout logic.

Parameters:
- N_CH, 8, number of TDC channels (1..64).
- INT_W, 11, coarse-count width per channel.
- FRAC_W, 11, fine-count width per channel.
- SCALE, 50, fine LSBs per coarse tick (constant multiplier, ≥1).
- ACC_W, 16, width of accumulation length and event counter.

Derived:
- SCALE_W = $clog2(SCALE+1).
- TERM_W = max(INT_W+SCALE_W, FRAC_W) + 1.
- TREE_ST = $clog2(N_CH), which is 0 when N_CH=1.
- SUM_W = TERM_W + TREE_ST.
- OUT_W = SUM_W + ACC_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- int_data  in  [INT_W-1:0] x N_CH  coarse counts, unpacked array.
- frac_data  in  [FRAC_W-1:0] x N_CH  fine counts, unpacked array.
- ch_mask  in  N_CH  channel enable; 0 forces that channel's term to 0; sampled with start.
- start  in  1  event strobe; inputs are valid in this cycle.
- acc_len  in  ACC_W  events per result; 0 or 1 means per-event output; sampled at the first event of each block.
- acc_clear  in  1  synchronous abort of the current accumulation block.
- out_sum  out  OUT_W  summed (and accumulated) time.
- out_cnt  out  ACC_W  number of events contained in out_sum.
- out_dval  out  1  single-cycle result strobe.
- busy  out  1  accumulation block in progress, or events still in flight in the pipeline.

Behaviour:
- Reset: out_sum=0, out_cnt=0, out_dval=0, busy=0. All pipeline registers, valid shift register, accumulator and counter are cleared. Reset mid-operation discards all in-flight events; no partial result is emitted.
- Stage 0 (cycle of start): register masked int, frac and mask. Unmasked channels pass their values; masked channels register as 0.
- Stage 1: term[i] = int_r[i]*SCALE + frac_r[i], TERM_W bits, unsigned, no truncation possible.
- Tree stages 1..TREE_ST: pairwise add, width +1 per stage. With an odd count, the last operand passes through zero-extended.
- Pipeline: a valid bit travels with the data and there are no bubbles. start is accepted every cycle; back-to-back events yield back-to-back results.
- Tree output valid at L = 2 + TREE_ST cycles after start, so L=5 for N_CH=8.
- Accumulator FSM, states IDLE and ACC:
  - IDLE, tree-valid with effective len ≤ 1: out_sum = tree sum zero-extended, out_cnt=1, out_dval=1 at cycle L+1. Remain in IDLE.
  - IDLE, tree-valid with len ≥ 2: acc=sum, cnt=1, latch len. Go to ACC.
  - ACC, tree-valid: acc+=sum, cnt+=1. When cnt+1 == len: out_sum=acc+sum, out_cnt=len, out_dval=1, clear acc and cnt, return to IDLE.
  - acc_len is sampled with the start that produced the block's first event. It travels down the pipeline alongside that event.
  - acc_clear in any state: acc=0, cnt=0, go to IDLE, no output. Events in flight complete and are treated as new-block events. If acc_clear and tree-valid occur in the same cycle, acc_clear wins and that event is dropped.
- out_sum and out_cnt hold their values between strobes; only out_dval pulses.
- Overflow cannot occur: acc ≤ (2^ACC_W−1)·(2^SUM_W−1) fits in OUT_W bits.
- busy = (state==ACC) | any pipeline valid bit set.

Decomposition:
- Package tdc_pkg holds:
  - the clog2-based width functions (SCALE_W, TERM_W, SUM_W, OUT_W) as constant functions;
  - the FSM state enum {IDLE, ACC};
  - the default SCALE constant.
- One sub-module, tdc_add_tree: generic registered pairwise adder tree parametrised by N and IN_W. It carries a valid bit and a sideband (acc_len) with equal latency.
- The top module holds the mask/multiply stage and the accumulator FSM.

Test Plan:
- N_CH=8, SCALE=50, mask=8'hFF, all int=1, frac=2, acc_len=0, single start -> out_dval exactly 6 cycles later; out_sum=416, out_cnt=1.
- Same inputs, mask=8'h0F -> out_sum=208; mask=8'h00 -> out_sum=0 and out_dval still pulses.
- 4 consecutive starts, ch0 int=2047 and frac=2047, others masked, acc_len=4 -> single out_dval; out_sum = 4×(2047·50+2047) = 417588, out_cnt=4. No strobe for the first 3 events.
- Back-to-back starts for 10 cycles, acc_len=0, with incrementing int -> 10 consecutive out_dval pulses, each sum correct and in order.
- acc_len=5, 3 events, then acc_clear -> no output; the next 5 events produce out_cnt=5 with only the new sums included.
- rst asserted asynchronously with 3 events in flight -> all outputs 0 immediately and no out_dval after release; N_CH=1 and N_CH=5 builds give latency 2 and 5 respectively.
